// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data RAM plus a memory-mapped
// peripheral block (reloading timer with sticky interrupt, LED and
// seven-segment registers, free-running system tick counter).
module mem_stage #(
  parameter int RAM_DEPTH     = 512,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_RegRtData,
  output logic [31:0] MEM_ReadData,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  logic [31:0]              addr_word;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic                     sel_ram;
  logic                     wr_en;
  logic                     unused_addr_lsb;

  // Byte offset within a word carries no meaning; every access is a full word.
  assign unused_addr_lsb = ^MEM_ALUOut[1:0];
  assign addr_word       = {MEM_ALUOut[31:2], 2'b00};
  assign ram_idx         = MEM_ALUOut[RAM_ADDR_BITS+1:2];
  assign sel_ram         = (MEM_ALUOut[31:RAM_ADDR_BITS+2] == '0);
  // Stores issued while reset is held must not touch RAM or registers.
  assign wr_en           = MEM_MemWrite && !reset;

  assign irq = tcon[2];

  // Data RAM store port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && sel_ram) begin
      ram[ram_idx] <= MEM_RegRtData;
    end
  end

  // Peripheral registers: tick counter, timer, then CPU stores, which are
  // placed last so a store to TL/TCON overrides the timer in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (tcon[0]) begin
        if (tl != 32'hFFFF_FFFF) begin
          tl <= tl + 32'd1;
        end else begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end
      end

      if (MEM_MemWrite) begin
        case (addr_word)
          ADDR_TH:     th     <= MEM_RegRtData;
          ADDR_TL:     tl     <= MEM_RegRtData;
          ADDR_TCON:   tcon   <= MEM_RegRtData[2:0];
          ADDR_LED:    leds   <= MEM_RegRtData[7:0];
          ADDR_DIGITS: digits <= MEM_RegRtData[11:0];
          default: ;
        endcase
      end
    end
  end

  // Combinational load path; reflects pre-store state during a store cycle.
  always_comb begin
    MEM_ReadData = '0;
    if (MEM_MemRead) begin
      if (sel_ram) begin
        MEM_ReadData = ram[ram_idx];
      end else begin
        case (addr_word)
          ADDR_TH:      MEM_ReadData = th;
          ADDR_TL:      MEM_ReadData = tl;
          ADDR_TCON:    MEM_ReadData = {29'd0, tcon};
          ADDR_LED:     MEM_ReadData = {24'd0, leds};
          ADDR_DIGITS:  MEM_ReadData = {20'd0, digits};
          ADDR_SYSTICK: MEM_ReadData = systick;
          default:      MEM_ReadData = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: RAM loads/stores, timer reload and
// interrupt, LED/digit registers, system tick and mid-run reset.
module tb_mem_stage;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_out;
  logic [31:0] rt_data;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int checks;
  int failures;

  mem_stage #(.RAM_DEPTH(512), .RAM_ADDR_BITS(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_MemRead  (mem_read),
    .MEM_MemWrite (mem_write),
    .MEM_ALUOut   (alu_out),
    .MEM_RegRtData(rt_data),
    .MEM_ReadData (read_data),
    .leds         (leds),
    .digits       (digits),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks enter and leave just after a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    alu_out   = a;
    rt_data   = d;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_read = 1'b1;
    alu_out  = a;
    #1;
    d        = read_data;
    mem_read = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_out = '0; rt_data = '0;
    tick(3);
    checks++;
    if ({leds, digits, irq} !== 21'd0) begin
      failures++; $display("FAIL reset_outputs got leds=%h digits=%h irq=%b exp 0", leds, digits, irq);
    end
    rd(A_SYSTICK, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_systick got %h exp 0", v); end
    rd(A_TCON, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL reset_tcon got %h exp 0", v); end
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read got %h exp deadbeef", v); end
    rd(32'h0000_0013, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read_unaligned got %h exp deadbeef", v); end
    rd(32'h0000_0800, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL ram_out_of_range got %h exp 0", v); end
    wr(32'h0000_07FC, 32'h0BAD_F00D);
    rd(32'h0000_07FC, v);
    checks++;
    if (v !== 32'h0BAD_F00D) begin failures++; $display("FAIL ram_last_word got %h exp 0badf00d", v); end
    alu_out = 32'h0000_0010; mem_read = 1'b0; #1;
    checks++;
    if (read_data !== 32'd0) begin failures++; $display("FAIL read_gated got %h exp 0", read_data); end
    mem_read = 1'b1; mem_write = 1'b1; rt_data = 32'h1234_5678; #1;
    checks++;
    if (read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_during_write got %h exp deadbeef", read_data); end
    @(negedge clk);
    mem_write = 1'b0; #1;
    checks++;
    if (read_data !== 32'h1234_5678) begin failures++; $display("FAIL write_next_cycle got %h exp 12345678", read_data); end
    mem_read = 1'b0;
  endtask

  task automatic test_timer();
    logic [31:0] v;
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL tl_enable_cycle got %h exp fffffffe", v); end
    tick(1);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFF || irq !== 1'b0) begin
      failures++; $display("FAIL tl_incr got tl=%h irq=%b exp ffffffff irq=0", v, irq);
    end
    tick(1);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFD || irq !== 1'b1) begin
      failures++; $display("FAIL tl_reload got tl=%h irq=%b exp fffffffd irq=1", v, irq);
    end
    rd(A_TCON, v);
    checks++;
    if (v !== 32'd7) begin failures++; $display("FAIL tcon_flag got %h exp 7", v); end
    tick(1);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFE || irq !== 1'b1) begin
      failures++; $display("FAIL irq_sticky got tl=%h irq=%b exp fffffffe irq=1", v, irq);
    end
    wr(A_TCON, 32'd3);
    rd(A_TL, v);
    checks++;
    if (irq !== 1'b0 || v !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL irq_clear got irq=%b tl=%h exp irq=0 tl=ffffffff", irq, v);
    end
    // TL is at all-ones: this store coincides with the overflow.
    wr(A_TCON, 32'd0);
    rd(A_TCON, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failures++; $display("FAIL overflow_vs_write tcon=%h irq=%b exp 0 0", v, irq);
    end
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFD) begin failures++; $display("FAIL overflow_reload got %h exp fffffffd", v); end
    tick(1);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFD) begin failures++; $display("FAIL timer_stopped got %h exp fffffffd", v); end
  endtask

  task automatic test_leds_digits();
    logic [31:0] v;
    wr(A_LED, 32'h0000_01A5);
    checks++;
    if (leds !== 8'hA5) begin failures++; $display("FAIL leds_out got %h exp a5", leds); end
    wr(A_DIGITS, 32'h0000_F3F2);
    checks++;
    if (digits !== 12'h3F2) begin failures++; $display("FAIL digits_out got %h exp 3f2", digits); end
    rd(A_LED, v);
    checks++;
    if (v !== 32'h0000_00A5) begin failures++; $display("FAIL leds_read got %h exp a5", v); end
    rd(A_DIGITS, v);
    checks++;
    if (v !== 32'h0000_03F2) begin failures++; $display("FAIL digits_read got %h exp 3f2", v); end
    wr(32'h4000_0018, 32'hFFFF_FFFF);
    rd(32'h4000_0018, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_read got %h exp 0", v); end
  endtask

  task automatic test_systick();
    logic [31:0] a;
    logic [31:0] b;
    rd(A_SYSTICK, a);
    tick(5);
    rd(A_SYSTICK, b);
    checks++;
    if (b - a !== 32'd5) begin failures++; $display("FAIL systick_delta got %0d exp 5", b - a); end
    rd(A_SYSTICK, a);
    wr(A_SYSTICK, 32'h0000_1234);
    rd(A_SYSTICK, b);
    checks++;
    if (b !== a + 32'd1) begin failures++; $display("FAIL systick_write got %h exp %h", b, a + 32'd1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(32'h0000_0020, 32'hCAFE_F00D);
    wr(A_LED, 32'h0000_00FF);
    wr(A_DIGITS, 32'h0000_0ABC);
    wr(A_TH, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    tick(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
    reset = 1'b1;
    mem_write = 1'b1; alu_out = 32'h0000_0020; rt_data = 32'h1111_1111;
    @(negedge clk);
    mem_write = 1'b0;
    checks++;
    if ({leds, digits, irq} !== 21'd0) begin
      failures++; $display("FAIL mid_reset_outputs got leds=%h digits=%h irq=%b exp 0", leds, digits, irq);
    end
    rd(A_TL, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL mid_reset_tl got %h exp 0", v); end
    reset = 1'b0;
    rd(32'h0000_0020, v);
    checks++;
    if (v !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_retained got %h exp cafef00d", v); end
    tick(2);
    rd(A_TL, v);
    checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      failures++; $display("FAIL timer_idle_after_reset got tl=%h irq=%b exp 0 0", v, irq);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ram();
    test_timer();
    test_leds_digits();
    test_systick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
